// File: rtl/seg_scan_driver_pkg.sv
// seg_scan_driver_pkg: segment patterns and scan timing defaults for the digit display.
package seg_scan_driver_pkg;
   localparam int SCAN_DIV_DEF     = 1000;
   localparam int DEAD_CYC_DEF     = 2;
   localparam int BLINK_FRAMES_DEF = 64;
   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;
   localparam logic [3:0] NIBBLE_DASH = 4'hA;
endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: digit/mask bus from the time blocks and the multiplexed segment outputs.
interface seg_scan_driver_if;
   logic [31:0] DIGITS;
   logic [7:0]  BLANK_MASK;
   logic [7:0]  BLINK_MASK;
   logic [7:0]  DP_MASK;
   logic [7:0]  SEG_COM;
   logic [7:0]  SEG_DATA;
   logic        FRAME_SYNC;
   modport master (output DIGITS, BLANK_MASK, BLINK_MASK, DP_MASK,
                   input  SEG_COM, SEG_DATA, FRAME_SYNC);
   modport slave  (input  DIGITS, BLANK_MASK, BLINK_MASK, DP_MASK,
                   output SEG_COM, SEG_DATA, FRAME_SYNC);
endinterface

// File: rtl/seg_scan_driver_seg7_decode.sv
// seg7_decode: BCD nibble to {g..a} pattern; A is a dash, B..F are blank.
module seg7_decode
   import seg_scan_driver_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);
   always_comb begin
      seg = SEG_OFF;
      case (nibble)
         4'd0:        seg = SEG_0;
         4'd1:        seg = SEG_1;
         4'd2:        seg = SEG_2;
         4'd3:        seg = SEG_3;
         4'd4:        seg = SEG_4;
         4'd5:        seg = SEG_5;
         4'd6:        seg = SEG_6;
         4'd7:        seg = SEG_7;
         4'd8:        seg = SEG_8;
         4'd9:        seg = SEG_9;
         NIBBLE_DASH: seg = SEG_DASH;
         default:     seg = SEG_OFF;
      endcase
   end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: scans 8 BCD digits onto a common-anode bank from a once-per-frame
// snapshot, with blanking, blinking and decimal points.
module seg_scan_driver
   import seg_scan_driver_pkg::*;
#(
   parameter int SCAN_DIV     = SCAN_DIV_DEF,
   parameter int DEAD_CYC     = DEAD_CYC_DEF,
   parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
   input  logic CLK,
   input  logic RESETN,
   seg_scan_driver_if.slave bus
);
   localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [FW-1:0] frame_cnt;
   logic          blink_phase;
   logic [31:0]   sh_digits;
   logic [7:0]    sh_blank, sh_blink, sh_dp;
   logic [6:0]    seg;
   logic          tick, snap, last_frame, dead, dark;
   assign tick       = cnt == CW'(SCAN_DIV - 1);
   assign snap       = tick & (idx == 3'd7);
   assign last_frame = frame_cnt == FW'(BLINK_FRAMES - 1);
   assign dead       = int'(cnt) < DEAD_CYC;
   assign dark       = sh_blank[idx] | (sh_blink[idx] & blink_phase);
   seg7_decode u_dec (.nibble(sh_digits[idx*4 +: 4]), .seg(seg));
   // Shadow regs reset to all-blank so nothing lights before the first snapshot.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         cnt            <= '0;
         idx            <= '0;
         frame_cnt      <= '0;
         blink_phase    <= 1'b0;
         sh_digits      <= '0;
         sh_blank       <= 8'hFF;
         sh_blink       <= '0;
         sh_dp          <= '0;
         bus.FRAME_SYNC <= 1'b0;
         bus.SEG_COM    <= 8'hFF;
         bus.SEG_DATA   <= 8'h00;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick) idx <= idx + 1'b1;
         if (snap) begin
            sh_digits   <= bus.DIGITS;
            sh_blank    <= bus.BLANK_MASK;
            sh_blink    <= bus.BLINK_MASK;
            sh_dp       <= bus.DP_MASK;
            frame_cnt   <= last_frame ? '0 : frame_cnt + 1'b1;
            blink_phase <= blink_phase ^ last_frame;
         end
         bus.FRAME_SYNC <= snap;
         bus.SEG_COM    <= dead ? 8'hFF : ~(8'b1 << idx);
         bus.SEG_DATA   <= (dead | dark) ? 8'h00 : {sh_dp[idx], seg};
      end
   end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed frame-by-frame checks of scan order, snapshotting,
// blanking, dash/dp, blinking and asynchronous reset.
module tb_seg_scan_driver;
   logic CLK = 1'b0;
   logic RESETN = 1'b0;
   int n_pass = 0;
   int n_chk = 0;
   localparam logic [63:0] FR_A   = 64'h077D6D664F5B063F;
   localparam logic [63:0] FR_B   = 64'h077D6D664F5B067F;
   localparam logic [63:0] FR_C   = 64'h077D6D664F5BC000;
   localparam logic [63:0] FR_OFF = 64'h007D6D664F5B063F;
   localparam logic [63:0] FR_ON  = 64'h6F7D6D664F5B063F;

   seg_scan_driver_if bus();
   seg_scan_driver #(.SCAN_DIV(4), .DEAD_CYC(1), .BLINK_FRAMES(2)) dut (
      .CLK(CLK), .RESETN(RESETN), .bus(bus));

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, got, exp);
   endtask

   // Starts at the release edge; every slot is dark because shadow blank is all ones.
   task automatic sync_after_reset();
      logic [7:0] com;
      for (int k = 1; k <= 32; k++) begin
         @(negedge CLK);
         com = ((k - 1) % 4 == 0) ? 8'hFF : ~(8'b1 << ((k - 1) / 4));
         check($sformatf("fs_rst%0d", k), {7'b0, bus.FRAME_SYNC}, {7'b0, k == 32});
         check($sformatf("com_rst%0d", k), bus.SEG_COM, com);
         check($sformatf("dark_rst%0d", k), bus.SEG_DATA, 8'h00);
      end
   endtask

   // Starts on a FRAME_SYNC cycle, ends on the next one.
   task automatic check_frame(input logic [63:0] exp, input bit chg);
      check("fs", {7'b0, bus.FRAME_SYNC}, 8'h01);
      for (int n = 0; n < 8; n++)
         for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            if (chg && n == 3 && c == 0) bus.DIGITS[3:0] = 4'h8;
            check($sformatf("com%0d", n), bus.SEG_COM, c == 0 ? 8'hFF : ~(8'b1 << n));
            check($sformatf("seg%0d", n), bus.SEG_DATA, c == 0 ? 8'h00 : exp[n*8 +: 8]);
         end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      bus.DIGITS     = 32'h76543210;
      bus.BLANK_MASK = 8'h00;
      bus.BLINK_MASK = 8'h00;
      bus.DP_MASK    = 8'h00;
      repeat (5) begin
         @(negedge CLK);
         check("rst_com", bus.SEG_COM, 8'hFF);
         check("rst_seg", bus.SEG_DATA, 8'h00);
         check("rst_fs", {7'b0, bus.FRAME_SYNC}, 8'h00);
      end
      RESETN = 1'b1;
      sync_after_reset();
      check_frame(FR_A, 1'b0);
      check_frame(FR_A, 1'b0);
      check_frame(FR_A, 1'b1);
      bus.BLANK_MASK = 8'h01;
      bus.DIGITS     = 32'h765432A8;
      bus.DP_MASK    = 8'h02;
      check_frame(FR_B, 1'b0);
      bus.BLANK_MASK = 8'h00;
      bus.DP_MASK    = 8'h00;
      bus.DIGITS     = 32'h96543210;
      bus.BLINK_MASK = 8'h80;
      check_frame(FR_C, 1'b0);
      check_frame(FR_OFF, 1'b0);
      check_frame(FR_OFF, 1'b0);
      check_frame(FR_ON, 1'b0);
      check_frame(FR_ON, 1'b0);
      repeat (22) @(negedge CLK);
      check("mid_com_pre", bus.SEG_COM, 8'hDF);
      #2 RESETN = 1'b0;
      #1;
      check("mid_com", bus.SEG_COM, 8'hFF);
      check("mid_seg", bus.SEG_DATA, 8'h00);
      check("mid_fs", {7'b0, bus.FRAME_SYNC}, 8'h00);
      @(negedge CLK);
      check("mid_com_hold", bus.SEG_COM, 8'hFF);
      @(negedge CLK);
      RESETN = 1'b1;
      sync_after_reset();
      check_frame(FR_ON, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
